uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clocks per bit period (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have port i_clk  input  1  rising-edge clock.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_uart_rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port i_ready  input  1  consumer accepts o_data when high with o_valid.
REQ-006 SHALL have port o_data  output  8  received byte, LSB first on the wire.
REQ-007 SHALL have port o_valid  output  1  o_data holds an unconsumed byte.
REQ-008 SHALL have port o_frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-009 SHALL have port o_overrun  output  1  one-cycle pulse when a byte is dropped.
REQ-010 SHALL have port o_parity_err  output  1  one-cycle pulse on parity mismatch.

Function
REQ-011 SHALL pass i_uart_rx through a 2-flop synchronizer before any use; all timing below refers to the synchronized line.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-013 SHALL leave IDLE for START on a high-to-low transition of the line and load the bit counter with CLKS_PER_BIT/2-1.
REQ-014 SHALL sample the line at the START mid-point: low -> DATA; high -> false start, return to IDLE with no output.
REQ-015 SHALL sample the 8 data bits at CLKS_PER_BIT intervals after the start mid-point and shift them in LSB first (3-bit index, 16-bit counter).
REQ-016 SHALL sample the stop bit one period after the last data or parity bit: high -> byte complete; low -> o_frame_err pulse, byte discarded, go to WAIT_HIGH.
REQ-017 SHALL stay in WAIT_HIGH until the line reads high, then return to IDLE (break tolerance).
REQ-018 SHALL assert o_valid and update o_data on the cycle after a good stop sample, and return to IDLE on that same cycle.
REQ-019 SHALL hold o_valid and o_data stable until a cycle with o_valid && i_ready, then deassert o_valid on the next cycle.
REQ-020 SHALL pulse o_overrun when a byte completes while o_valid is high and i_ready is low; the new byte is dropped and o_data keeps the old byte.
REQ-021 SHALL, on a byte completing in the same cycle as an o_valid && i_ready handshake, load the new byte, keep o_valid high and not pulse o_overrun.
REQ-022 SHALL treat o_frame_err, o_overrun and o_parity_err as mutually independent single-cycle pulses.

Reset
REQ-023 SHALL on i_rst force: state IDLE, synchronizer flops 1, o_data 8'h00, o_valid 0, o_frame_err 0, o_overrun 0, o_parity_err 0, counters 0.
REQ-024 SHALL abandon any frame in progress on reset mid-frame, and SHALL NOT treat a line already low when reset deasserts as a start bit until the line has been seen high.

Configuration
REQ-025 SHALL support macro UART_RX_PARITY_EN: when defined, one even-parity bit follows bit 7 and is sampled in PARITY; on mismatch o_parity_err pulses with the stop-bit check, the byte is discarded, and the stop-bit check and WAIT_HIGH rule are unchanged.
REQ-026 SHALL, without UART_RX_PARITY_EN, omit PARITY (DATA goes straight to STOP) and tie o_parity_err to 0.

Structure
REQ-027 SHALL put the state enum type and the constants DATA_BITS=8 and IDLE_LEVEL=1'b1 in shared package uart_pkg, reused by the transmitter.
REQ-028 SHALL instantiate sub-module uart_sync2 (parameterless 2-flop synchronizer, reset value 1).

Verification
REQ-029 Byte 8'hA5 at CLKS_PER_BIT=16, i_ready=1 -> o_valid for 1 cycle with o_data=8'hA5, no error pulses.
REQ-030 Start pulse low for 4 clocks then high -> no o_valid and no errors; FSM back in IDLE.
REQ-031 Byte 8'h3C with stop bit low, then line held low for 50 clocks -> one o_frame_err pulse, no o_valid; next good byte 8'h81 is received correctly.
REQ-032 i_ready=0, bytes 8'h11 then 8'h22 -> o_valid held with o_data=8'h11 and one o_overrun pulse; after i_ready=1, 8'h11 is consumed once.
REQ-033 i_ready asserted on the exact cycle the second byte 8'h22 completes -> o_data=8'h22, o_valid stays high, no o_overrun.
REQ-034 With UART_RX_PARITY_EN defined, byte 8'h07 sent with parity bit 0 -> one o_parity_err pulse, no o_valid; with parity bit 1 -> o_data=8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and frame constants.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module uart_sync2
    import uart_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= IDLE_LEVEL;
            sync_q <= IDLE_LEVEL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 with ready/valid output and error pulses.
// Define UART_RX_PARITY_EN to add one even-parity bit after bit 7.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_uart_rx,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_parity_err
);

    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_IDX  = 3'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic                 rx_s;
    logic [1:0]           flush_q;
    logic                 line_hi_q;
    logic [15:0]          cnt_q;
    logic [2:0]           idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, ferr_q, ovr_q;
    logic                 tick, start_edge, byte_done;
    logic                 load_half, load_full, shift_en, stop_en;
`ifdef UART_RX_PARITY_EN
    logic                 par_en, par_bad_q, perr_q;
`endif

    uart_sync2 u_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .async_i(i_uart_rx),
        .sync_o (rx_s)
    );

    // line_hi_q only tracks real samples once the synchronizer has flushed its
    // reset value, so a line held low through reset is never seen as a start edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            flush_q   <= '0;
            line_hi_q <= 1'b0;
        end else begin
            flush_q <= {flush_q[0], 1'b1};
            if (flush_q[1]) line_hi_q <= rx_s;
        end
    end

    assign tick       = (cnt_q == '0);
    assign start_edge = line_hi_q & ~rx_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (start_edge) state_d = START;
            START:     if (tick) state_d = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:      if (tick && idx_q == LAST_IDX) state_d = PARITY;
            PARITY:    if (tick) state_d = STOP;
`else
            DATA:      if (tick && idx_q == LAST_IDX) state_d = STOP;
`endif
            STOP:      if (tick) state_d = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s == IDLE_LEVEL) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        load_half = 1'b0;
        load_full = 1'b0;
        shift_en  = 1'b0;
        stop_en   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en    = 1'b0;
`endif
        unique case (state_q)
            IDLE:  load_half = start_edge;
            START: load_full = tick;
            DATA: begin
                load_full = tick;
                shift_en  = tick;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                load_full = tick;
                par_en    = tick;
            end
`endif
            STOP:    stop_en = tick;
            default: ;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign byte_done = stop_en & rx_s & ~par_bad_q;
`else
    assign byte_done = stop_en & rx_s;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            if (load_half)      cnt_q <= HALF_LOAD;
            else if (load_full) cnt_q <= FULL_LOAD;
            else if (!tick)     cnt_q <= cnt_q - 16'd1;

            if (load_half)     idx_q <= '0;
            else if (shift_en) idx_q <= idx_q + 3'd1;

            if (shift_en) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            if (load_half)   par_bad_q <= 1'b0;
            else if (par_en) par_bad_q <= (^shift_q) ^ rx_s;
            perr_q <= stop_en & par_bad_q;
        end
    end
    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

    // A byte completing during a handshake replaces the consumed one; otherwise
    // a pending byte wins and the new one is dropped with an overrun pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= stop_en & ~rx_s;
            ovr_q  <= byte_done & valid_q & ~i_ready;
            if (byte_done && (!valid_q || i_ready)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && i_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;

endmodule
